// File: rtl/sandbox_link_pkg.sv
// Shared constants and state encodings for the sandbox host link.
// Frames are one control/status byte followed by a 32-bit word, MSB first.
package sandbox_link_pkg;

  localparam int FRAME_BYTES = 5;
  localparam logic [2:0] LAST_INDEX = 3'(FRAME_BYTES - 1);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_COLLECT,
    RX_HOLD,
    RX_RELEASE
  } rx_state_t;

  typedef enum logic {
    TX_IDLE,
    TX_SEND
  } tx_state_t;

endpackage

// File: rtl/sandbox_link_tx.sv
// Reply serializer: a rising edge of transmitData latches status/outputData
// and streams the five bytes out over a valid/ready byte handshake.
module sandbox_link_tx
  import sandbox_link_pkg::*;
(
  input  logic        masterClock,
  input  logic        reset,
  input  logic        transmitData,
  input  logic [7:0]  status,
  input  logic [31:0] outputData,
  input  logic        txByteReady,
  output logic        txByteValid,
  output logic [7:0]  txByte
);

  tx_state_t   state_reg, state_next;
  logic [2:0]  index_reg, index_next;
  logic [39:0] frame_reg, frame_next;
  logic        transmit_prev_reg;
  logic        transmit_rise;

  assign transmit_rise = transmitData & ~transmit_prev_reg;

  always_ff @(posedge masterClock or posedge reset) begin
    if (reset) begin
      state_reg         <= TX_IDLE;
      index_reg         <= '0;
      frame_reg         <= '0;
      transmit_prev_reg <= 1'b0;
    end else begin
      state_reg         <= state_next;
      index_reg         <= index_next;
      frame_reg         <= frame_next;
      transmit_prev_reg <= transmitData;
    end
  end

  // Edges seen while a frame is in flight are dropped, not queued.
  always_comb begin
    state_next = state_reg;
    index_next = index_reg;
    frame_next = frame_reg;
    case (state_reg)
      TX_IDLE: begin
        if (transmit_rise) begin
          frame_next = {status, outputData};
          index_next = '0;
          state_next = TX_SEND;
        end
      end
      TX_SEND: begin
        if (txByteReady) begin
          if (index_reg == LAST_INDEX) begin
            index_next = '0;
            state_next = TX_IDLE;
          end else begin
            index_next = index_reg + 3'd1;
          end
        end
      end
      default: state_next = TX_IDLE;
    endcase
  end

  assign txByteValid = (state_reg == TX_SEND);

  always_comb begin
    txByte = 8'h00;
    if (state_reg == TX_SEND) begin
      case (index_reg)
        3'd0:    txByte = frame_reg[39:32];
        3'd1:    txByte = frame_reg[31:24];
        3'd2:    txByte = frame_reg[23:16];
        3'd3:    txByte = frame_reg[15:8];
        default: txByte = frame_reg[7:0];
      endcase
    end
  end

endmodule

// File: rtl/sandbox_host_link.sv
// Host-side endpoint: assembles 5-byte command frames from the host byte
// stream and hands them to the process; replies go through sandbox_link_tx.
module sandbox_host_link
  import sandbox_link_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        masterClock,
  input  logic        reset,
  input  logic        rxByteValid,
  input  logic [7:0]  rxByte,
  input  logic        txByteReady,
  output logic        txByteValid,
  output logic [7:0]  txByte,
  output logic        dataReceived,
  output logic [7:0]  control,
  output logic [31:0] inputData,
  input  logic        clearDR,
  input  logic        transmitData,
  input  logic [7:0]  status,
  input  logic [31:0] outputData,
  output logic        rxOverrun,
  output logic        rxTimeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] IDLE_LIMIT = CW'(TIMEOUT_CYCLES - 1);

  rx_state_t     state_reg, state_next;
  logic [2:0]    count_reg, count_next;
  logic [7:0]    control_reg, control_next;
  logic [31:0]   data_reg, data_next;
  logic [CW-1:0] idle_reg, idle_next;
  logic          overrun_reg, overrun_next;
  logic          timeout_reg, timeout_next;

  always_ff @(posedge masterClock or posedge reset) begin
    if (reset) begin
      state_reg   <= RX_IDLE;
      count_reg   <= '0;
      control_reg <= '0;
      data_reg    <= '0;
      idle_reg    <= '0;
      overrun_reg <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      control_reg <= control_next;
      data_reg    <= data_next;
      idle_reg    <= idle_next;
      overrun_reg <= overrun_next;
      timeout_reg <= timeout_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    control_next = control_reg;
    data_next    = data_reg;
    idle_next    = idle_reg;
    overrun_next = overrun_reg;
    timeout_next = timeout_reg;
    case (state_reg)
      RX_IDLE: begin
        if (rxByteValid) begin
          control_next = rxByte;
          count_next   = 3'd1;
          idle_next    = '0;
          state_next   = RX_COLLECT;
        end
      end
      RX_COLLECT: begin
        // A byte landing in the expiry cycle is taken and the timeout skipped.
        if (rxByteValid) begin
          data_next  = {data_reg[23:0], rxByte};
          idle_next  = '0;
          count_next = count_reg + 3'd1;
          if (count_reg == LAST_INDEX) begin
            state_next = RX_HOLD;
          end
        end else if (idle_reg == IDLE_LIMIT) begin
          timeout_next = 1'b1;
          count_next   = '0;
          state_next   = RX_IDLE;
        end else begin
          idle_next = idle_reg + 1'b1;
        end
      end
      RX_HOLD: begin
        if (rxByteValid) overrun_next = 1'b1;
        if (clearDR) state_next = RX_RELEASE;
      end
      RX_RELEASE: begin
        if (rxByteValid) overrun_next = 1'b1;
        if (!clearDR) state_next = RX_IDLE;
      end
      default: state_next = RX_IDLE;
    endcase
  end

  assign dataReceived = (state_reg == RX_HOLD);
  assign control      = control_reg;
  assign inputData    = data_reg;
  assign rxOverrun    = overrun_reg;
  assign rxTimeout    = timeout_reg;

  sandbox_link_tx u_tx (
    .masterClock (masterClock),
    .reset       (reset),
    .transmitData(transmitData),
    .status      (status),
    .outputData  (outputData),
    .txByteReady (txByteReady),
    .txByteValid (txByteValid),
    .txByte      (txByte)
  );

endmodule

// File: tb/tb_sandbox_host_link.sv
// Scoreboard bench for sandbox_host_link: stimulus pushes expected frames and
// bytes into queues, a negedge monitor pops and compares as the DUT emits them.
module tb_sandbox_host_link;

  logic        masterClock = 1'b0;
  logic        reset = 1'b1;
  logic        rxByteValid = 1'b0;
  logic [7:0]  rxByte = 8'h00;
  logic        txByteReady = 1'b0;
  logic        txByteValid;
  logic [7:0]  txByte;
  logic        dataReceived;
  logic [7:0]  control;
  logic [31:0] inputData;
  logic        clearDR = 1'b0;
  logic        transmitData = 1'b0;
  logic [7:0]  status = 8'h00;
  logic [31:0] outputData = 32'h0;
  logic        rxOverrun;
  logic        rxTimeout;

  int n_checks = 0;
  int n_fail = 0;

  logic [39:0] exp_rx[$];
  logic [7:0]  exp_tx[$];

  logic       prev_dr = 1'b0;
  logic       hold_pending = 1'b0;
  logic [7:0] held_byte = 8'h00;

  sandbox_host_link #(.TIMEOUT_CYCLES(16)) dut (
    .masterClock (masterClock),
    .reset       (reset),
    .rxByteValid (rxByteValid),
    .rxByte      (rxByte),
    .txByteReady (txByteReady),
    .txByteValid (txByteValid),
    .txByte      (txByte),
    .dataReceived(dataReceived),
    .control     (control),
    .inputData   (inputData),
    .clearDR     (clearDR),
    .transmitData(transmitData),
    .status      (status),
    .outputData  (outputData),
    .rxOverrun   (rxOverrun),
    .rxTimeout   (rxTimeout)
  );

  always #5 masterClock = ~masterClock;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endfunction

  // Monitor: compares every presented frame and every byte transfer.
  always @(negedge masterClock) begin
    if (!reset) begin
      if (dataReceived && !prev_dr) begin
        if (exp_rx.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rx_unexpected: got frame %02h_%08h, required none", control, inputData);
        end else begin
          chk("rx_frame", {control, inputData}, exp_rx.pop_front());
        end
      end
      if (hold_pending && txByteValid) chk("tx_stable", txByte, held_byte);
      if (txByteValid && txByteReady) begin
        if (exp_tx.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL tx_unexpected: got byte %02h, required none", txByte);
        end else begin
          chk("tx_byte", txByte, exp_tx.pop_front());
        end
      end
      hold_pending <= txByteValid && !txByteReady;
      held_byte    <= txByte;
    end else begin
      hold_pending <= 1'b0;
    end
    prev_dr <= dataReceived;
  end

  task automatic tick();
    @(posedge masterClock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rxByteValid = 1'b1;
    rxByte = b;
    tick();
    rxByteValid = 1'b0;
  endtask

  task automatic send_frame(input logic [39:0] f);
    for (int i = 4; i >= 0; i--) send_byte(f[i*8 +: 8]);
  endtask

  task automatic release_frame();
    clearDR = 1'b1;
    tick();
    chk("dr_after_clear", dataReceived, 0);
    clearDR = 1'b0;
    tick();
  endtask

  task automatic push_reply(input logic [7:0] s, input logic [31:0] d);
    exp_tx.push_back(s);
    exp_tx.push_back(d[31:24]);
    exp_tx.push_back(d[23:16]);
    exp_tx.push_back(d[15:8]);
    exp_tx.push_back(d[7:0]);
  endtask

  task automatic wait_tx_done(input bit toggle, input int max_cycles);
    for (int i = 0; i < max_cycles && txByteValid; i++) begin
      if (toggle) txByteReady = ~txByteReady;
      tick();
    end
    chk("tx_done", txByteValid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_txvalid", txByteValid, 0);
    chk("rst_txbyte", txByte, 0);
    chk("rst_dr", dataReceived, 0);
    chk("rst_ctrl_data", {control, inputData}, 0);
    chk("rst_flags", {rxOverrun, rxTimeout}, 0);
    reset = 1'b0;
    tick();

    // Basic frame, one byte per cycle
    exp_rx.push_back(40'h01_DEADBEEF);
    send_frame(40'h01_DEADBEEF);
    chk("dr_after_frame", dataReceived, 1);
    release_frame();

    // Reply with toggling ready; inputs change after the latch
    status = 8'h03;
    outputData = 32'h12345678;
    push_reply(8'h03, 32'h12345678);
    txByteReady = 1'b0;
    transmitData = 1'b1;
    tick();
    chk("tx_first_valid", txByteValid, 1);
    chk("tx_first_byte", txByte, 8'h03);
    status = 8'hFF;
    outputData = 32'h0;
    transmitData = 1'b0;
    wait_tx_done(1'b1, 30);
    txByteReady = 1'b0;
    tick();

    // Overrun: sixth byte arrives while the frame is held
    exp_rx.push_back(40'h01_DEADBEEF);
    send_frame(40'h01_DEADBEEF);
    send_byte(8'h55);
    chk("overrun_flag", rxOverrun, 1);
    chk("overrun_data", inputData, 32'hDEADBEEF);
    chk("overrun_dr", dataReceived, 1);
    release_frame();
    exp_rx.push_back(40'h77_01020304);
    send_frame(40'h77_01020304);
    chk("dr_after_overrun", dataReceived, 1);
    release_frame();

    // Timeout: three bytes then idle; boundary at 15 vs 16 idle cycles
    send_byte(8'h09);
    send_byte(8'h08);
    send_byte(8'h07);
    for (int i = 0; i < 15; i++) tick();
    chk("timeout_not_yet", rxTimeout, 0);
    tick();
    chk("timeout_flag", rxTimeout, 1);
    chk("timeout_no_dr", dataReceived, 0);
    tick();
    exp_rx.push_back(40'h00_0000002A);
    send_frame(40'h00_0000002A);
    chk("dr_after_timeout", dataReceived, 1);
    release_frame();

    // A byte in the expiry cycle wins over the timeout
    exp_rx.push_back(40'h11_22334455);
    send_byte(8'h11);
    send_byte(8'h22);
    for (int i = 0; i < 15; i++) tick();
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h55);
    chk("dr_expiry_byte", dataReceived, 1);
    release_frame();

    // Retrigger during a send is ignored; a later edge sends again
    status = 8'hA5;
    outputData = 32'h0BADF00D;
    txByteReady = 1'b1;
    push_reply(8'hA5, 32'h0BADF00D);
    transmitData = 1'b1;
    tick();
    transmitData = 1'b0;
    tick();
    transmitData = 1'b1;
    tick();
    transmitData = 1'b0;
    wait_tx_done(1'b0, 20);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_requeue", txByteValid, 0);
    end
    push_reply(8'hA5, 32'h0BADF00D);
    transmitData = 1'b1;
    tick();
    transmitData = 1'b0;
    wait_tx_done(1'b0, 20);

    // Reset mid-operation after two RX and two TX bytes
    status = 8'h3C;
    outputData = 32'h600DCAFE;
    exp_tx.push_back(8'h3C);
    exp_tx.push_back(8'h60);
    rxByteValid = 1'b1;
    rxByte = 8'h99;
    transmitData = 1'b1;
    tick();
    rxByte = 8'h98;
    tick();
    rxByteValid = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk("mid_rst_txvalid", txByteValid, 0);
    chk("mid_rst_txbyte", txByte, 0);
    chk("mid_rst_dr", dataReceived, 0);
    chk("mid_rst_ctrl_data", {control, inputData}, 0);
    chk("mid_rst_flags", {rxOverrun, rxTimeout}, 0);
    tick();
    push_reply(8'h3C, 32'h600DCAFE);
    reset = 1'b0;
    tick();
    chk("post_rst_send", txByteValid, 1);
    transmitData = 1'b0;
    wait_tx_done(1'b0, 20);
    exp_rx.push_back(40'h5A_CAFEF00D);
    send_frame(40'h5A_CAFEF00D);
    chk("dr_after_reset", dataReceived, 1);
    release_frame();

    for (int i = 0; i < 4; i++) tick();
    chk("rx_queue_drained", exp_rx.size(), 0);
    chk("tx_queue_drained", exp_tx.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
